// File: rtl/instr_encoder.sv
// Control-bundle to 16-bit instruction encoder with a first-word-fall-through
// output FIFO and a saturating counter of illegal bundles.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [13:0]   in_ctrl,
    input  logic [2:0]    in_rs,
    input  logic [2:0]    in_rt,
    input  logic [2:0]    in_rd,
    input  logic [2:0]    in_funct,
    input  logic [5:0]    in_imm,
    input  logic [11:0]   in_jaddr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_instr,
    output logic [AW:0]   count,
    output logic          err_illegal,
    output logic [7:0]    illegal_cnt
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J
    } fmt_e;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic [7:0]    icnt_q, icnt_d;

    logic [3:0]    op;
    logic          legal;
    fmt_e          fmt;
    logic [15:0]   word;
    logic          accept, push, pop;

    // Field order: rd rw as alu_op mr mw mtr beq bne blt bgt jump
    always_comb begin
        op    = 4'h0;
        legal = 1'b1;
        fmt   = FMT_I;
        unique casez (in_ctrl)
            14'b1_1_0_000_0_0_0_0_0_0_0_0: begin op = 4'h0; fmt = FMT_R; end
            14'b0_1_1_001_0_0_0_0_0_0_0_0: op = 4'h1;
            14'b0_1_1_010_0_0_0_0_0_0_0_0: op = 4'h2;
            14'b0_1_1_011_0_0_0_0_0_0_0_0: op = 4'h3;
            14'b0_1_1_100_0_0_0_0_0_0_0_0: op = 4'h4;
            14'b0_1_1_001_1_0_1_0_0_0_0_0: op = 4'h7;
            14'b?_1_1_001_0_1_0_0_0_0_0_0: op = 4'h8;
            14'b?_0_0_101_0_0_?_1_0_0_0_0: op = 4'h9;
            14'b?_0_0_101_0_0_?_0_1_0_0_0: op = 4'hA;
            14'b?_0_0_101_0_0_?_0_0_1_0_0: op = 4'hB;
            14'b?_0_0_101_0_0_?_0_0_0_1_0: op = 4'hC;
            14'b?_0_0_001_0_0_?_0_0_0_0_1: begin op = 4'hF; fmt = FMT_J; end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        word = {op, in_rs, in_rt, in_imm};
        unique case (fmt)
            FMT_R:   word = {op, in_rs, in_rt, in_rd, in_funct};
            FMT_J:   word = {op, in_jaddr};
            default: word = {op, in_rs, in_rt, in_imm};
        endcase
    end

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid & in_ready;
    assign push      = accept & legal & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
        err_d  = accept & ~legal;
        icnt_d = icnt_q;
        if (err_d && icnt_q != 8'hFF)
            icnt_d = icnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            icnt_q  <= '0;
        end else begin
            if (push)
                mem_q[wptr_q] <= word;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            icnt_q  <= icnt_d;
        end
    end

    assign out_instr   = out_valid ? mem_q[rptr_q] : 16'h0000;
    assign count       = count_q;
    assign err_illegal = err_q;
    assign illegal_cnt = icnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding, FIFO ordering/full/empty,
// illegal-bundle handling, flush and asynchronous reset.
module tb_instr_encoder;

    localparam logic [13:0] C_R    = 14'h3000;
    localparam logic [13:0] C_ADDI = 14'h1900;
    localparam logic [13:0] C_ANDI = 14'h1A00;
    localparam logic [13:0] C_ORI  = 14'h1B00;
    localparam logic [13:0] C_SUBI = 14'h1C00;
    localparam logic [13:0] C_LHW  = 14'h19A0;
    localparam logic [13:0] C_SHW  = 14'h1940;
    localparam logic [13:0] C_BEQ  = 14'h0510;
    localparam logic [13:0] C_BNE  = 14'h0508;
    localparam logic [13:0] C_BLT  = 14'h0504;
    localparam logic [13:0] C_BGT  = 14'h0502;
    localparam logic [13:0] C_JMP  = 14'h0101;
    localparam logic [13:0] C_BAD  = 14'h0518;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_ctrl = '0;
    logic [2:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_funct = '0;
    logic [5:0]  in_imm = '0;
    logic [11:0] in_jaddr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [2:0]  count;
    logic        err_illegal;
    logic [7:0]  illegal_cnt;

    int checks = 0;
    int failures = 0;

    instr_encoder dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_jaddr(in_jaddr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .count(count),
        .err_illegal(err_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [13:0] c, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [5:0] imm);
        in_ctrl  = c;
        in_rs    = rs;
        in_rt    = rt;
        in_imm   = imm;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [13:0] rt_ctrl [14];
    logic [3:0]  rt_op   [14];

    initial begin
        rt_ctrl = '{C_R, C_ADDI, C_ANDI, C_ORI, C_SUBI, C_LHW, C_SHW,
                    C_SHW | 14'h2000, C_BEQ, C_BNE | 14'h2020, C_BLT,
                    C_BGT, C_JMP, C_JMP | 14'h2020};
        rt_op   = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8,
                    4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF, 4'hF};

        #12;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_instr", 32'(out_instr), 0);
        check("rst_err", 32'(err_illegal), 0);
        check("rst_icnt", 32'(illegal_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        push(C_ADDI, 3'd1, 3'd2, 6'd5);
        check("addi_valid", 32'(out_valid), 1);
        check("addi_word", 32'(out_instr), 32'h1285);
        check("addi_count", 32'(count), 1);
        pop();
        check("pop_empty_instr", 32'(out_instr), 0);
        check("pop_empty_count", 32'(count), 0);

        in_rd = 3'd5;
        in_funct = 3'd2;
        push(C_R, 3'd3, 3'd4, 6'd0);
        check("r_word", 32'(out_instr), 32'h072A);
        pop();
        push(C_BEQ, 3'd1, 3'd1, 6'h3E);
        check("beq_word", 32'(out_instr), 32'h927E);
        pop();
        in_jaddr = 12'h0AB;
        push(C_JMP, 3'd0, 3'd0, 6'd0);
        check("jmp_word", 32'(out_instr), 32'hF0AB);
        pop();

        for (int i = 0; i < 5; i++) begin
            push(C_ADDI, 3'd0, 3'd0, 6'(i));
            check("fill_count", 32'(count), (i < 4) ? i + 1 : 4);
        end
        check("full_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 4; i++) begin
            check("drain_word", 32'(out_instr), 32'h1000 + i);
            pop();
        end
        check("drain_count", 32'(count), 0);
        check("drain_valid", 32'(out_valid), 0);

        push(C_BAD, 3'd0, 3'd0, 6'd0);
        check("ill_err", 32'(err_illegal), 1);
        check("ill_cnt", 32'(illegal_cnt), 1);
        check("ill_count", 32'(count), 0);
        tick();
        check("ill_err_pulse", 32'(err_illegal), 0);

        push(C_ORI, 3'd0, 3'd0, 6'd1);
        push(C_ORI, 3'd0, 3'd0, 6'd2);
        in_ctrl = C_ORI;
        in_imm = 6'd3;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("pp_count", 32'(count), 2);
        check("pp_head", 32'(out_instr), 32'h3002);

        flush = 1'b1;
        push(C_ANDI, 3'd0, 3'd0, 6'd7);
        flush = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_valid", 32'(out_valid), 0);
        flush = 1'b1;
        push(C_BAD, 3'd0, 3'd0, 6'd0);
        flush = 1'b0;
        check("flush_ill_err", 32'(err_illegal), 1);
        check("flush_ill_cnt", 32'(illegal_cnt), 2);

        for (int i = 0; i < 4; i++)
            push(C_SUBI, 3'd0, 3'd0, 6'(i));
        in_ctrl = C_SUBI;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("full_pop_count", 32'(count), 3);
        check("full_pop_head", 32'(out_instr), 32'h4001);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        in_ctrl = C_BAD;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++)
            tick();
        in_valid = 1'b0;
        check("sat_cnt", 32'(illegal_cnt), 255);
        check("sat_count", 32'(count), 0);

        in_jaddr = 12'h000;
        for (int i = 0; i < 14; i++) begin
            push(rt_ctrl[i], 3'd0, 3'd0, 6'd0);
            check("rt_valid", 32'(out_valid), 1);
            check("rt_op", 32'(out_instr[15:12]), 32'(rt_op[i]));
            pop();
        end

        push(C_ADDI, 3'd1, 3'd1, 6'd1);
        push(C_ADDI, 3'd1, 3'd1, 6'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_instr", 32'(out_instr), 0);
        check("arst_icnt", 32'(illegal_cnt), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
